// File: rtl/core_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : core_wb_stage_if
//  Purpose  : MEM->WB instruction handshake, data-memory read response and
//             register-file write port of the RV32I writeback stage, bundled
//             as one interface.
//  Modports : slave  - the writeback stage (consumes i_*, drives o_*)
//             master - the MEM stage / memory side (drives i_*, observes o_*)
//  Revision : 1.0  initial release
// ============================================================================
interface core_wb_stage_if #(
    parameter int XLEN = 32
);
    // MEM -> WB instruction
    logic            i_valid;
    logic            o_ready;
    logic [4:0]      i_rd;
    logic            i_reg_write;
    logic            i_mem_read;
    logic [1:0]      i_mem_to_reg;
    logic [1:0]      i_d_size;
    logic            i_d_unsigned;
    logic [1:0]      i_addr_lo;
    logic [XLEN-1:0] i_alu_result;
    logic [XLEN-1:0] i_pc_plus4;
    // data-memory read response
    logic            i_dmem_rvalid;
    logic [XLEN-1:0] i_dmem_rdata;
    // register-file write port and status pulses
    logic [4:0]      o_wb_rd;
    logic [XLEN-1:0] o_rd_din;
    logic            o_wb_reg_write;
    logic            o_retire;
    logic            o_misaligned;
    logic            o_load_timeout;

    modport slave (
        input  i_valid, i_rd, i_reg_write, i_mem_read, i_mem_to_reg,
               i_d_size, i_d_unsigned, i_addr_lo, i_alu_result, i_pc_plus4,
               i_dmem_rvalid, i_dmem_rdata,
        output o_ready, o_wb_rd, o_rd_din, o_wb_reg_write, o_retire,
               o_misaligned, o_load_timeout
    );

    modport master (
        output i_valid, i_rd, i_reg_write, i_mem_read, i_mem_to_reg,
               i_d_size, i_d_unsigned, i_addr_lo, i_alu_result, i_pc_plus4,
               i_dmem_rvalid, i_dmem_rdata,
        input  o_ready, o_wb_rd, o_rd_din, o_wb_reg_write, o_retire,
               o_misaligned, o_load_timeout
    );
endinterface : core_wb_stage_if
`default_nettype wire

// File: rtl/core_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : core_wb_stage
//  Purpose  : Writeback stage of the 5-stage RV32I pipeline. Accepts one
//             instruction per cycle, selects ALU / load / PC+4 as the result,
//             waits for the data-memory response on loads (stalling upstream
//             via o_ready), aligns and extends load data, and drives the
//             register-file write port with registered outputs.
//  Ports    : i_clk    - core clock
//             i_rst_n  - synchronous active-low reset
//             wb_bus   - core_wb_stage_if.slave (handshake, dmem response,
//                        register-file write port, status pulses)
//  Revision : 1.0  initial release
// ============================================================================
module core_wb_stage #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 64   // 0 disables the load timeout
) (
    input  wire             i_clk,
    input  wire             i_rst_n,
    core_wb_stage_if.slave  wb_bus
);

    localparam int c_CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(LOAD_TIMEOUT - 1);
    localparam bit                 c_TO_EN    = (LOAD_TIMEOUT != 0);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic                r_out_of_reset;

    // load context captured at accept, used when the response arrives later
    logic [4:0]          r_ld_rd;
    logic                r_ld_reg_write;
    logic [1:0]          r_ld_size;
    logic                r_ld_unsigned;
    logic [1:0]          r_ld_addr_lo;

    // registered writeback outputs and their next values
    logic [4:0]          r_wb_rd,       w_wb_rd;
    logic [XLEN-1:0]     r_rd_din,      w_rd_din;
    logic                r_wb_we,       w_wb_we;
    logic                r_retire,      w_retire;
    logic                r_misaligned,  w_misaligned;
    logic                r_load_to,     w_load_to;
    logic                w_capture;

    logic                w_ready;
    logic                w_accept;
    logic                w_is_load;
    logic                w_misalign_in;

    // Select the addressed byte/half of the word-aligned read data and
    // extend it to XLEN. Size 11 is treated as a full word.
    function automatic logic [XLEN-1:0] f_align(
        input logic [XLEN-1:0] rdata,
        input logic [1:0]      size,
        input logic            uns,
        input logic [1:0]      lo
    );
        logic [7:0]  v_b;
        logic [15:0] v_h;
        v_b = rdata[{lo, 3'b000} +: 8];
        v_h = rdata[{lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   f_align = uns ? {{(XLEN-8){1'b0}}, v_b}
                               : {{(XLEN-8){v_b[7]}}, v_b};
            2'b01:   f_align = uns ? {{(XLEN-16){1'b0}}, v_h}
                               : {{(XLEN-16){v_h[15]}}, v_h};
            default: f_align = rdata;
        endcase
    endfunction

    // Ready is held low while reset is asserted and rises in the first cycle
    // after release.
    assign w_ready       = (r_state == S_IDLE) && r_out_of_reset;
    assign w_accept      = wb_bus.i_valid && w_ready;
    assign w_is_load     = wb_bus.i_mem_read && (wb_bus.i_mem_to_reg == 2'b01);
    assign w_misalign_in = ((wb_bus.i_d_size == 2'b01) && wb_bus.i_addr_lo[0]) ||
                           (wb_bus.i_d_size[1] && (wb_bus.i_addr_lo != 2'b00));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;
        w_wb_rd      = r_wb_rd;
        w_rd_din     = r_rd_din;
        w_wb_we      = 1'b0;
        w_retire     = 1'b0;
        w_misaligned = 1'b0;
        w_load_to    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_load) begin
                        if (w_misalign_in) begin
                            // dropped: the response is never awaited
                            w_retire     = 1'b1;
                            w_misaligned = 1'b1;
                        end else if (wb_bus.i_dmem_rvalid) begin
                            w_retire = 1'b1;
                            w_wb_we  = wb_bus.i_reg_write && (wb_bus.i_rd != 5'd0);
                            if (w_wb_we) begin
                                w_wb_rd  = wb_bus.i_rd;
                                w_rd_din = f_align(wb_bus.i_dmem_rdata, wb_bus.i_d_size,
                                                   wb_bus.i_d_unsigned, wb_bus.i_addr_lo);
                            end
                        end else begin
                            w_capture   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_WAIT_LOAD;
                        end
                    end else begin
                        w_retire = 1'b1;
                        w_wb_we  = wb_bus.i_reg_write && (wb_bus.i_rd != 5'd0);
                        if (w_wb_we) begin
                            w_wb_rd  = wb_bus.i_rd;
                            w_rd_din = (wb_bus.i_mem_to_reg == 2'b10) ? wb_bus.i_pc_plus4
                                                                      : wb_bus.i_alu_result;
                        end
                    end
                end
            end

            S_WAIT_LOAD: begin
                if (wb_bus.i_dmem_rvalid) begin
                    w_retire    = 1'b1;
                    w_wb_we     = r_ld_reg_write && (r_ld_rd != 5'd0);
                    if (w_wb_we) begin
                        w_wb_rd  = r_ld_rd;
                        w_rd_din = f_align(wb_bus.i_dmem_rdata, r_ld_size,
                                           r_ld_unsigned, r_ld_addr_lo);
                    end
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (c_TO_EN && (r_cnt == c_TO_LAST)) begin
                    w_retire    = 1'b1;
                    w_load_to   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_out_of_reset <= 1'b0;
            r_ld_rd        <= 5'd0;
            r_ld_reg_write <= 1'b0;
            r_ld_size      <= 2'b00;
            r_ld_unsigned  <= 1'b0;
            r_ld_addr_lo   <= 2'b00;
            r_wb_rd        <= 5'd0;
            r_rd_din       <= '0;
            r_wb_we        <= 1'b0;
            r_retire       <= 1'b0;
            r_misaligned   <= 1'b0;
            r_load_to      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_out_of_reset <= 1'b1;
            r_wb_rd        <= w_wb_rd;
            r_rd_din       <= w_rd_din;
            r_wb_we        <= w_wb_we;
            r_retire       <= w_retire;
            r_misaligned   <= w_misaligned;
            r_load_to      <= w_load_to;
            if (w_capture) begin
                r_ld_rd        <= wb_bus.i_rd;
                r_ld_reg_write <= wb_bus.i_reg_write;
                r_ld_size      <= wb_bus.i_d_size;
                r_ld_unsigned  <= wb_bus.i_d_unsigned;
                r_ld_addr_lo   <= wb_bus.i_addr_lo;
            end
        end
    end

    assign wb_bus.o_ready        = w_ready;
    assign wb_bus.o_wb_rd        = r_wb_rd;
    assign wb_bus.o_rd_din       = r_rd_din;
    assign wb_bus.o_wb_reg_write = r_wb_we;
    assign wb_bus.o_retire       = r_retire;
    assign wb_bus.o_misaligned   = r_misaligned;
    assign wb_bus.o_load_timeout = r_load_to;

endmodule : core_wb_stage
`default_nettype wire
